// File: rtl/axi_rd_slave_ram.sv
// AXI4 read-channel responder backed by an internal word RAM.
// A side load port fills the RAM. Bursts are served as INCR or FIXED,
// and illegal requests are answered with SLVERR beats at normal pace.
module axi_rd_slave_ram #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          AW        = 12
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic [31:0]   ARADDR,
  input  logic [7:0]    ARLEN,
  input  logic [2:0]    ARSIZE,
  input  logic [1:0]    ARBURST,
  input  logic          ARVALID,
  output logic          ARREADY,
  output logic [31:0]   RDATA,
  output logic [1:0]    RRESP,
  output logic          RLAST,
  output logic          RVALID,
  input  logic          RREADY,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  localparam int          DEPTH     = 1 << AW;
  localparam logic [31:0] MEM_BYTES = 32'd4 << AW;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA} state_t;

  logic [31:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          fixed_q, fixed_d;
  logic          err_q, err_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic          rlast_q, rlast_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [31:0]   ar_off;
  logic          ar_err;
  logic          rd_en;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] ptr_step;

  // Burst decode: offset from the window base and the legality of the request
  assign ar_off = ARADDR - BASE_ADDR;
  assign ar_err = (ar_off >= MEM_BYTES) || (ARSIZE != 3'h2) || (ARBURST > 2'd1);

  // Pointer for the following beat: FIXED stays put, INCR advances with wrap
  assign ptr_step = fixed_q ? ptr_q : ptr_q + {{(AW-1){1'b0}}, 1'b1};

  // Load port write; a same-cycle bus read of this word still sees the old value
  always_ff @(posedge ACLK) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Next-state and registered-output computation for the burst engine
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    fixed_d  = fixed_q;
    err_d    = err_q;
    rvalid_d = rvalid_q;
    rlast_d  = rlast_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    rd_en    = 1'b0;
    rd_ptr   = ptr_q;

    case (state_q)
      S_IDLE: begin
        if (ARVALID && arready_q) begin
          ptr_d   = ar_off[AW+1:2];
          cnt_d   = ARLEN;
          fixed_d = (ARBURST == 2'd0);
          err_d   = ar_err;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_en    = 1'b1;
        rvalid_d = 1'b1;
        rlast_d  = (cnt_q == 8'd0);
        rresp_d  = err_q ? 2'b10 : 2'b00;
        state_d  = S_DATA;
      end
      S_DATA: begin
        if (rvalid_q && RREADY) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            state_d  = S_IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_ptr  = ptr_step;
            ptr_d   = ptr_step;
            cnt_d   = cnt_q - 8'd1;
            rlast_d = (cnt_q == 8'd1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_en) begin
      rdata_d = err_q ? 32'd0 : mem[rd_ptr];
    end

    arready_d = (state_d == S_IDLE);
  end

  // State and output registers; a reset aborts any burst in flight
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      fixed_q   <= fixed_d;
      err_q     <= err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_rd_slave_ram.sv
// Testbench for axi_rd_slave_ram: directed and randomized bursts compared
// against a burst-level model of the RAM window.
module tb_axi_rd_slave_ram;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          AW    = 12;
  localparam int          DEPTH = 4096;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [31:0]   ARADDR = '0;
  logic [7:0]    ARLEN = '0;
  logic [2:0]    ARSIZE = 3'h2;
  logic [1:0]    ARBURST = 2'd1;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [31:0]   RDATA;
  logic [1:0]    RRESP;
  logic          RLAST;
  logic          RVALID;
  logic          RREADY = 1'b0;
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [31:0]   ld_data = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] refMem  [DEPTH];
  logic [31:0] expData [256];
  logic [1:0]  expResp [256];

  axi_rd_slave_ram #(.BASE_ADDR(BASE), .AW(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  // Free-running bus clock
  always #5 ACLK = ~ACLK;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write one RAM word through the load port and mirror it in the model
  task automatic loadWord(input int addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr[AW-1:0];
    ld_data = data;
    @(posedge ACLK); #1;
    ld_en = 1'b0;
    refMem[addr] = data;
  endtask

  // Expected beats of a burst, derived from the address window rules
  task automatic buildModel(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int wrBeat, input int wrAddr,
                            input logic [31:0] wrData);
    logic [31:0] off;
    bit          err;
    int          start, word;
    off   = addr - BASE;
    err   = (off >= 32'h0000_4000) || (size != 3'h2) || (burst > 2'd1);
    start = int'((off >> 2) & 32'h0000_0FFF);
    for (int j = 0; j <= len; j++) begin
      word = (burst == 2'd0) ? start : (start + j) % DEPTH;
      if (err) begin
        expData[j] = 32'd0;
        expResp[j] = 2'b10;
      end else begin
        expData[j] = refMem[word];
        if (wrBeat > 0 && j > wrBeat && word == wrAddr) expData[j] = wrData;
        expResp[j] = 2'b00;
      end
    end
  endtask

  // Run one burst: AR handshake, then collect and check every R beat.
  // readyMode 0 = always ready, 1 = 1-on/2-off, 2 = random.
  // wrBeat > 0 loads wrAddr during that beat's RAM read; resetBeat >= 0 resets while that beat is shown.
  task automatic applyStimulus(input string name, input logic [31:0] addr, input int len,
                               input logic [2:0] size, input logic [1:0] burst, input int readyMode,
                               input int wrBeat, input int wrAddr, input logic [31:0] wrData,
                               input int resetBeat);
    bit hs, hsOk, done, firstSeen, rdy, taken, wrote;
    int cyc, idx, k;
    buildModel(addr, len, size, burst, wrBeat, wrAddr, wrData);
    ARADDR  = addr;
    ARLEN   = len[7:0];
    ARSIZE  = size;
    ARBURST = burst;
    ARVALID = 1'b1;
    RREADY  = 1'b0;
    hsOk = 0;
    for (int w = 0; w < 50; w++) begin
      hs = ARREADY;
      @(posedge ACLK); #1;
      if (hs) begin hsOk = 1; break; end
    end
    ARVALID = 1'b0;
    if (!hsOk) begin
      checkOutput({name, "_ar_timeout"}, 32'd0, 32'd1);
      return;
    end
    checkOutput({name, "_fetch_rvalid"}, {31'd0, RVALID}, 32'd0);
    checkOutput({name, "_fetch_arready"}, {31'd0, ARREADY}, 32'd0);
    cyc = 1; idx = 0; k = 0; done = 0; firstSeen = 0; wrote = 0;
    for (int t = 0; t < 3000 && !done; t++) begin
      taken = 0;
      if (RVALID) begin
        if (!firstSeen) begin
          firstSeen = 1;
          checkOutput({name, "_latency"}, cyc, 32'd2);
        end
        checkOutput($sformatf("%s_arready%0d", name, idx), {31'd0, ARREADY}, 32'd0);
        checkOutput($sformatf("%s_rdata%0d", name, idx), RDATA, expData[idx]);
        checkOutput($sformatf("%s_rresp%0d", name, idx), {30'd0, RRESP}, {30'd0, expResp[idx]});
        checkOutput($sformatf("%s_rlast%0d", name, idx), {31'd0, RLAST}, {31'd0, idx == len});
        if (idx == resetBeat) begin
          ARESETn = 1'b0;
          RREADY  = 1'b0;
          #1;
          checkOutput({name, "_rst_rvalid"}, {31'd0, RVALID}, 32'd0);
          checkOutput({name, "_rst_arready"}, {31'd0, ARREADY}, 32'd0);
          checkOutput({name, "_rst_rlast"}, {31'd0, RLAST}, 32'd0);
          checkOutput({name, "_rst_rdata"}, RDATA, 32'd0);
          checkOutput({name, "_rst_rresp"}, {30'd0, RRESP}, 32'd0);
          @(posedge ACLK); #1;
          ARESETn = 1'b1;
          checkOutput({name, "_rel_arready0"}, {31'd0, ARREADY}, 32'd0);
          @(posedge ACLK); #1;
          checkOutput({name, "_rel_arready1"}, {31'd0, ARREADY}, 32'd1);
          return;
        end
        case (readyMode)
          0:       rdy = 1'b1;
          1:       rdy = (k % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        k++;
        RREADY = rdy;
        taken  = rdy;
        if (rdy && wrBeat > 0 && idx == wrBeat - 1) begin
          ld_en   = 1'b1;
          ld_addr = wrAddr[AW-1:0];
          ld_data = wrData;
          wrote   = 1;
        end
      end else begin
        RREADY = 1'($urandom_range(0, 1));
      end
      @(posedge ACLK); #1;
      cyc++;
      if (wrote) begin
        ld_en = 1'b0;
        refMem[wrAddr] = wrData;
        wrote = 0;
      end
      if (taken) begin
        idx++;
        if (idx > len) begin
          done = 1;
          checkOutput({name, "_end_rvalid"}, {31'd0, RVALID}, 32'd0);
          checkOutput({name, "_end_arready"}, {31'd0, ARREADY}, 32'd1);
        end
      end
    end
    RREADY = 1'b0;
    if (!done) checkOutput({name, "_r_timeout"}, 32'd0, 32'd1);
  endtask

  // Main sequence: reset, preload, directed scenarios, then random bursts
  initial begin
    int sel, len, rmode;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  burst;

    repeat (2) @(posedge ACLK);
    #1;
    checkOutput("reset_arready", {31'd0, ARREADY}, 32'd0);
    checkOutput("reset_rvalid", {31'd0, RVALID}, 32'd0);
    checkOutput("reset_rlast", {31'd0, RLAST}, 32'd0);
    checkOutput("reset_rresp", {30'd0, RRESP}, 32'd0);
    checkOutput("reset_rdata", RDATA, 32'd0);

    for (int i = 0; i < DEPTH; i++) begin
      loadWord(i, (i < 16) ? 32'hA000_0000 + 32'(i) : $urandom);
    end

    ARESETn = 1'b1;
    checkOutput("release_arready0", {31'd0, ARREADY}, 32'd0);
    @(posedge ACLK); #1;
    checkOutput("release_arready1", {31'd0, ARREADY}, 32'd1);

    $display("[TB] directed bursts");
    applyStimulus("incr16", BASE, 15, 3'h2, 2'd1, 0, -1, 0, 32'd0, -1);
    applyStimulus("incr16_bp", BASE, 15, 3'h2, 2'd1, 1, -1, 0, 32'd0, -1);
    applyStimulus("wrap", BASE + 32'h0000_3FF8, 3, 3'h2, 2'd1, 0, -1, 0, 32'd0, -1);
    applyStimulus("err_range", BASE + 32'h0000_4000, 3, 3'h2, 2'd1, 0, -1, 0, 32'd0, -1);
    applyStimulus("err_size", BASE, 3, 3'h1, 2'd1, 0, -1, 0, 32'd0, -1);
    applyStimulus("err_burst", BASE, 3, 3'h2, 2'd2, 0, -1, 0, 32'd0, -1);
    applyStimulus("fixed", BASE + 32'd20, 7, 3'h2, 2'd0, 0, -1, 0, 32'd0, -1);
    applyStimulus("fixed_coll", BASE + 32'd20, 7, 3'h2, 2'd0, 0, 3, 5, 32'h5EED_0005, -1);
    applyStimulus("reset_mid", BASE, 15, 3'h2, 2'd1, 0, -1, 0, 32'd0, 6);
    applyStimulus("after_reset", BASE, 15, 3'h2, 2'd1, 0, -1, 0, 32'd0, -1);

    $display("[TB] random bursts");
    for (int n = 0; n < 30; n++) begin
      sel   = $urandom_range(0, 9);
      addr  = BASE + ($urandom_range(0, DEPTH - 1) << 2) + $urandom_range(0, 3);
      len   = $urandom_range(0, 15);
      size  = 3'h2;
      burst = 2'($urandom_range(0, 1));
      rmode = $urandom_range(0, 2);
      if (sel == 0) addr = BASE - 32'($urandom_range(1, 100) * 4);
      if (sel == 1) size = 3'($urandom_range(0, 1));
      if (sel == 2) burst = 2'($urandom_range(2, 3));
      applyStimulus($sformatf("rnd%0d", n), addr, len, size, burst, rmode, -1, 0, 32'd0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
